// File: rtl/m_axis_rc_adapt_if.sv
// Bundle of the core-facing RC stream and the legacy-format output stream.
// master: the PCIe core side plus the downstream consumer (drives RC beats, output ready).
// slave : the adapter (consumes RC beats, drives the legacy stream).
interface m_axis_rc_adapt_if #(
   parameter int DATA_WIDTH = 128,
   parameter int KEEP_WIDTH = DATA_WIDTH / 8
);
   logic [DATA_WIDTH-1:0] m_axis_rc_tdata;
   logic [3:0]            m_axis_rc_tkeep;
   logic                  m_axis_rc_tlast;
   logic [74:0]           m_axis_rc_tuser;
   logic                  m_axis_rc_tvalid;
   logic [21:0]           m_axis_rc_tready;

   logic [DATA_WIDTH-1:0] m_axis_rc_tdata_a;
   logic [KEEP_WIDTH-1:0] m_axis_rc_tkeep_a;
   logic                  m_axis_rc_tlast_a;
   logic [3:0]            m_axis_rc_tuser_a;
   logic                  m_axis_rc_tvalid_a;
   logic                  m_axis_rc_tready_a;

   modport master (
      output m_axis_rc_tdata, m_axis_rc_tkeep, m_axis_rc_tlast, m_axis_rc_tuser,
             m_axis_rc_tvalid,
      input  m_axis_rc_tready,
      input  m_axis_rc_tdata_a, m_axis_rc_tkeep_a, m_axis_rc_tlast_a, m_axis_rc_tuser_a,
             m_axis_rc_tvalid_a,
      output m_axis_rc_tready_a
   );

   modport slave (
      input  m_axis_rc_tdata, m_axis_rc_tkeep, m_axis_rc_tlast, m_axis_rc_tuser,
             m_axis_rc_tvalid,
      output m_axis_rc_tready,
      output m_axis_rc_tdata_a, m_axis_rc_tkeep_a, m_axis_rc_tlast_a, m_axis_rc_tuser_a,
             m_axis_rc_tvalid_a,
      input  m_axis_rc_tready_a
   );
endinterface

// File: rtl/m_axis_rc_adapt.sv
// Requester-completion adapter: converts 128-bit RC descriptor-format completions
// into legacy 3-DW-header completion TLPs, with a payload length check and a
// 2-entry registered skid buffer on the output.
//
// state | meaning
// HDR   | next accepted beat is an RC descriptor beat
// PKT   | payload beats of the current completion follow
module m_axis_rc_adapt #(
   parameter int DATA_WIDTH = 128,
   parameter int KEEP_WIDTH = DATA_WIDTH / 8
) (
   input  logic              user_clk,
   input  logic              user_reset_n,
   m_axis_rc_adapt_if.slave  rc_if
);

   typedef enum logic {S_HDR = 1'b0, S_PKT = 1'b1} state_t;

   typedef struct packed {
      logic [DATA_WIDTH-1:0] data;
      logic [KEEP_WIDTH-1:0] keep;
      logic                  last;
      logic [3:0]            user;
   } beat_t;

   state_t      state_q, state_nxt;
   logic        is_hdr;
   logic        tready_q;
   logic        accept;
   logic [10:0] rem_q, rem_nxt;
   logic        ep_q;

   logic [DATA_WIDTH-1:0] d;
   logic [3:0]            k;

   logic [11:0] f_addr;
   logic [3:0]  f_err;
   logic [12:0] f_bc;
   logic        f_lock;
   logic [10:0] f_dwc;
   logic [2:0]  f_st;
   logic        f_ep;
   logic [15:0] f_rid;
   logic [7:0]  f_tag;
   logic [15:0] f_cid;
   logic [2:0]  f_tc;
   logic [2:0]  f_attr;

   logic        ep_now;
   logic [31:0] hdr_dw0, hdr_dw1, hdr_dw2;
   logic [2:0]  keep_pop;
   logic        len_bad;
   beat_t       in_beat;

   beat_t       ent0_q, ent1_q;
   logic [1:0]  cnt_q, cnt_nxt;
   logic        pop;

   logic        unused_tuser;

   assign d      = rc_if.m_axis_rc_tdata;
   assign k      = rc_if.m_axis_rc_tkeep;
   assign accept = rc_if.m_axis_rc_tvalid & tready_q;

   assign f_addr = d[11:0];
   assign f_err  = d[15:12];
   assign f_bc   = d[28:16];
   assign f_lock = d[29];
   assign f_dwc  = d[42:32];
   assign f_st   = d[45:43];
   assign f_ep   = d[46];
   assign f_rid  = d[63:48];
   assign f_tag  = d[71:64];
   assign f_cid  = d[87:72];
   assign f_tc   = d[91:89];
   assign f_attr = d[94:92];

   // Only discontinue is consumed from the core sideband.
   assign unused_tuser = ^{rc_if.m_axis_rc_tuser[74:43], rc_if.m_axis_rc_tuser[41:0]};

   // FSM state register
   always_ff @(posedge user_clk or negedge user_reset_n) begin
      if (!user_reset_n) state_q <= S_HDR;
      else               state_q <= state_nxt;
   end

   // FSM next-state: packet boundaries are taken from tlast only
   always_comb begin
      state_nxt = state_q;
      case (state_q)
         S_HDR:   if (accept && !rc_if.m_axis_rc_tlast) state_nxt = S_PKT;
         S_PKT:   if (accept &&  rc_if.m_axis_rc_tlast) state_nxt = S_HDR;
         default: state_nxt = S_HDR;
      endcase
   end

   // FSM output decode
   always_comb begin
      is_hdr = (state_q == S_HDR);
   end

   // Legacy header build, remaining-length arithmetic and output beat assembly
   always_comb begin
      ep_now   = f_ep | (f_err != 4'd0);
      hdr_dw0  = {((f_dwc != 11'd0) ? 3'b010 : 3'b000),
                  (f_lock ? 5'b01011 : 5'b01010),
                  1'b0, f_tc, 4'b0000, 1'b0, ep_now, f_attr[1:0], 2'b00, f_dwc[9:0]};
      hdr_dw1  = {f_cid, f_st, 1'b0, f_bc[11:0]};
      hdr_dw2  = {f_rid, f_tag, 1'b0, f_addr[6:0]};
      keep_pop = 3'(k[0]) + 3'(k[1]) + 3'(k[2]) + 3'(k[3]);
      if (is_hdr) rem_nxt = f_dwc - {10'd0, k[3]};
      else        rem_nxt = rem_q - {8'd0, keep_pop};
      len_bad  = rc_if.m_axis_rc_tlast & (rem_nxt != 11'd0);

      in_beat      = '0;
      in_beat.data = is_hdr ? {d[127:96], hdr_dw2, hdr_dw1, hdr_dw0} : d;
      for (int i = 0; i < 4; i++) in_beat.keep[4*i +: 4] = {4{k[i]}};
      in_beat.last = rc_if.m_axis_rc_tlast;
      in_beat.user = {is_hdr, len_bad, (is_hdr ? ep_now : ep_q), rc_if.m_axis_rc_tuser[42]};
   end

   // Per-packet context: remaining dword count and the EP flag seen at beat 0
   always_ff @(posedge user_clk or negedge user_reset_n) begin
      if (!user_reset_n) begin
         rem_q <= 11'd0;
         ep_q  <= 1'b0;
      end else if (accept) begin
         rem_q <= rem_nxt;
         if (is_hdr) ep_q <= ep_now;
      end
   end

   // Skid buffer occupancy after this cycle's push/pop
   always_comb begin
      pop     = (cnt_q != 2'd0) & rc_if.m_axis_rc_tready_a;
      cnt_nxt = cnt_q;
      if (accept && !pop)      cnt_nxt = cnt_q + 2'd1;
      else if (pop && !accept) cnt_nxt = cnt_q - 2'd1;
   end

   // Skid buffer storage; ent0 is the presented head, ready is registered off occupancy
   always_ff @(posedge user_clk or negedge user_reset_n) begin
      if (!user_reset_n) begin
         ent0_q   <= '0;
         ent1_q   <= '0;
         cnt_q    <= 2'd0;
         tready_q <= 1'b0;
      end else begin
         cnt_q    <= cnt_nxt;
         tready_q <= (cnt_nxt != 2'd2);
         case ({accept, pop})
            2'b10: begin
               if (cnt_q == 2'd0) ent0_q <= in_beat;
               else               ent1_q <= in_beat;
            end
            2'b01: ent0_q <= ent1_q;
            2'b11: begin
               if (cnt_q == 2'd1) ent0_q <= in_beat;
               else begin
                  ent0_q <= ent1_q;
                  ent1_q <= in_beat;
               end
            end
            default: ;
         endcase
      end
   end

   assign rc_if.m_axis_rc_tready   = {22{tready_q}};
   assign rc_if.m_axis_rc_tvalid_a = (cnt_q != 2'd0);
   assign rc_if.m_axis_rc_tdata_a  = ent0_q.data;
   assign rc_if.m_axis_rc_tkeep_a  = ent0_q.keep;
   assign rc_if.m_axis_rc_tlast_a  = ent0_q.last;
   assign rc_if.m_axis_rc_tuser_a  = ent0_q.user;

endmodule

// File: tb/tb_m_axis_rc_adapt.sv
`timescale 1ns/1ps
module tb_m_axis_rc_adapt;

   typedef struct packed {
      logic [127:0] d;
      logic [15:0]  k;
      logic         l;
      logic [3:0]   u;
   } exp_t;

   logic user_clk;
   logic user_reset_n;
   m_axis_rc_adapt_if #(.DATA_WIDTH(128)) bus ();

   m_axis_rc_adapt #(.DATA_WIDTH(128)) dut (
      .user_clk     (user_clk),
      .user_reset_n (user_reset_n),
      .rc_if        (bus)
   );

   int   checks = 0;
   int   errors = 0;
   int   acc_cnt = 0;
   int   cyc = 0;
   exp_t exp_q[$];

   logic  stall_q = 1'b0;
   exp_t  held;

   initial begin
      user_clk = 1'b0;
      forever #5 user_clk = ~user_clk;
   end

   always @(posedge user_clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [95:0] desc(
      input logic [11:0] addr, input logic [3:0] err, input logic [12:0] bc,
      input logic lock, input logic [10:0] dwc, input logic [2:0] st, input logic ep,
      input logic [15:0] rid, input logic [7:0] tag, input logic [15:0] cid,
      input logic [2:0] tc, input logic [2:0] attr);
      logic [95:0] r;
      r = '0;
      r[11:0]  = addr;  r[15:12] = err;  r[28:16] = bc;  r[29]    = lock;
      r[42:32] = dwc;   r[45:43] = st;   r[46]    = ep;  r[63:48] = rid;
      r[71:64] = tag;   r[87:72] = cid;  r[91:89] = tc;  r[94:92] = attr;
      return r;
   endfunction

   // Present one RC beat, queue its expected output, return 1ns after the accepting edge
   task automatic send(input logic [127:0] d, input logic [3:0] k, input logic l,
                       input logic sof, input logic disc,
                       input logic [127:0] ed, input logic [15:0] ek, input logic [3:0] eu);
      logic [74:0] u;
      int budget;
      exp_t e;
      bit ok;
      u = '0; u[32] = sof; u[42] = disc;
      e.d = ed; e.k = ek; e.l = l; e.u = eu;
      bus.m_axis_rc_tdata  = d;
      bus.m_axis_rc_tkeep  = k;
      bus.m_axis_rc_tlast  = l;
      bus.m_axis_rc_tuser  = u;
      bus.m_axis_rc_tvalid = 1'b1;
      budget = 200;
      ok = 1'b0;
      while (budget > 0) begin
         @(negedge user_clk);
         if (bus.m_axis_rc_tready[0]) begin ok = 1'b1; break; end
         budget--;
      end
      if (ok) begin
         exp_q.push_back(e);
         @(posedge user_clk);
         #1;
         acc_cnt++;
      end else begin
         checks++; errors++;
         $display("FAIL accept_timeout: got tready=0 expected tready=1 within 200 cycles");
      end
      bus.m_axis_rc_tvalid = 1'b0;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 300) begin
         @(posedge user_clk);
         n++;
      end
      #1;
      chk("drain_queue_empty", 128'(exp_q.size()), 128'd0);
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_tvalid_a"}, 128'(bus.m_axis_rc_tvalid_a), 128'd0);
      chk({tag, "_tlast_a"},  128'(bus.m_axis_rc_tlast_a),  128'd0);
      chk({tag, "_tuser_a"},  128'(bus.m_axis_rc_tuser_a),  128'd0);
      chk({tag, "_tready"},   128'(bus.m_axis_rc_tready),   128'd0);
   endtask

   // 4-beat CplD: descriptor + 1 payload DW, then three full payload beats
   task automatic send_cpl4(input logic [7:0] tag, input logic [31:0] exp_dw2,
                            input logic [31:0] base);
      logic [127:0] p;
      send({base, desc(12'h000, 4'h0, 13'd52, 1'b0, 11'd13, 3'd0, 1'b0, 16'h0600, tag,
                       16'h0000, 3'd0, 3'd0)}, 4'hF, 1'b0, 1'b1, 1'b0,
           {base, exp_dw2, 32'h00000034, 32'h4A00000D}, 16'hFFFF, 4'b1000);
      for (int j = 1; j <= 3; j++) begin
         p = {base + 32'(4*j), base + 32'(4*j-1), base + 32'(4*j-2), base + 32'(4*j-3)};
         send(p, 4'hF, (j == 3), 1'b0, 1'b0, p, 16'hFFFF, 4'b0000);
      end
   endtask

   // Output monitor: pops the scoreboard on each transfer and checks hold during stalls
   always @(negedge user_clk) begin
      exp_t e;
      if (stall_q) begin
         chk("stall_hold_valid", 128'(bus.m_axis_rc_tvalid_a), 128'd1);
         chk("stall_hold_beat",
             {bus.m_axis_rc_tdata_a ^ held.d,
              bus.m_axis_rc_tkeep_a ^ held.k,
              bus.m_axis_rc_tlast_a ^ held.l,
              bus.m_axis_rc_tuser_a ^ held.u} == '0 ? 128'd0 : 128'd1, 128'd0);
      end
      if (bus.m_axis_rc_tvalid_a && bus.m_axis_rc_tready_a) begin
         if (exp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_beat: got data %h expected no beat", bus.m_axis_rc_tdata_a);
         end else begin
            e = exp_q.pop_front();
            chk("out_tdata", bus.m_axis_rc_tdata_a, e.d);
            chk("out_tkeep", 128'(bus.m_axis_rc_tkeep_a), 128'(e.k));
            chk("out_tlast", 128'(bus.m_axis_rc_tlast_a), 128'(e.l));
            chk("out_tuser", 128'(bus.m_axis_rc_tuser_a), 128'(e.u));
         end
      end
      stall_q = bus.m_axis_rc_tvalid_a && !bus.m_axis_rc_tready_a;
      held.d  = bus.m_axis_rc_tdata_a;
      held.k  = bus.m_axis_rc_tkeep_a;
      held.l  = bus.m_axis_rc_tlast_a;
      held.u  = bus.m_axis_rc_tuser_a;
   end

   initial begin
      int c0;
      int a0;
      int n;
      user_reset_n = 1'b0;
      bus.m_axis_rc_tdata    = '0;
      bus.m_axis_rc_tkeep    = '0;
      bus.m_axis_rc_tlast    = 1'b0;
      bus.m_axis_rc_tuser    = '0;
      bus.m_axis_rc_tvalid   = 1'b0;
      bus.m_axis_rc_tready_a = 1'b1;

      #23;
      chk_reset_outputs("por");
      @(posedge user_clk); #1;
      user_reset_n = 1'b1;
      chk("por_tready_before_edge", 128'(bus.m_axis_rc_tready), 128'd0);
      @(posedge user_clk); #1;
      chk("por_tready_after_edge", 128'(bus.m_axis_rc_tready), 128'h3FFFFF);

      // 1-DW CplD
      send({32'hDEADBEEF, desc(12'h004, 4'h0, 13'd4, 1'b0, 11'd1, 3'd0, 1'b0, 16'h0100, 8'h05,
                               16'h0000, 3'd0, 3'd0)}, 4'hF, 1'b1, 1'b1, 1'b0,
           {32'hDEADBEEF, 32'h01000504, 32'h00000004, 32'h4A000001}, 16'hFFFF, 4'b1000);
      chk("latency_valid_after_accept", 128'(bus.m_axis_rc_tvalid_a), 128'd1);

      // 8-DW CplD in 3 beats, nonzero tc/attr/cid
      send({32'h11110000, desc(12'h010, 4'h0, 13'd32, 1'b0, 11'd8, 3'd0, 1'b0, 16'h0200, 8'h11,
                               16'h0008, 3'b101, 3'b110)}, 4'hF, 1'b0, 1'b1, 1'b0,
           {32'h11110000, 32'h02001110, 32'h00080020, 32'h4A502008}, 16'hFFFF, 4'b1000);
      send(128'h44444444_33333333_22222222_11111111, 4'hF, 1'b0, 1'b0, 1'b0,
           128'h44444444_33333333_22222222_11111111, 16'hFFFF, 4'b0000);
      send(128'hCAFEF00D_77777777_66666666_55555555, 4'h7, 1'b1, 1'b0, 1'b0,
           128'hCAFEF00D_77777777_66666666_55555555, 16'h0FFF, 4'b0000);

      // UR completion, no payload, byte count 4096
      send({32'h00000000, desc(12'h000, 4'h0, 13'h1000, 1'b0, 11'd0, 3'b001, 1'b0, 16'h0300,
                               8'h22, 16'h0000, 3'd0, 3'd0)}, 4'h7, 1'b1, 1'b1, 1'b0,
           {32'h00000000, 32'h03002200, 32'h00002000, 32'h0A000000}, 16'h0FFF, 4'b1000);

      // Truncated locked completion: dwc=8 but only 5 DW delivered
      send({32'hA0A0A0A0, desc(12'h00C, 4'h0, 13'd32, 1'b1, 11'd8, 3'd0, 1'b0, 16'h0400, 8'h33,
                               16'h0010, 3'd0, 3'd0)}, 4'hF, 1'b0, 1'b1, 1'b0,
           {32'hA0A0A0A0, 32'h0400330C, 32'h00100020, 32'h4B000008}, 16'hFFFF, 4'b1000);
      send(128'hB3B3B3B3_B2B2B2B2_B1B1B1B1_B0B0B0B0, 4'hF, 1'b1, 1'b0, 1'b0,
           128'hB3B3B3B3_B2B2B2B2_B1B1B1B1_B0B0B0B0, 16'hFFFF, 4'b0100);

      // Error-status completion: EP forced, held across beats; discontinue on last beat
      send({32'hC0C0C0C0, desc(12'h008, 4'h1, 13'd8, 1'b0, 11'd2, 3'd0, 1'b0, 16'h0500, 8'h44,
                               16'h0000, 3'd0, 3'd0)}, 4'hF, 1'b0, 1'b1, 1'b0,
           {32'hC0C0C0C0, 32'h05004408, 32'h00000008, 32'h4A004002}, 16'hFFFF, 4'b1010);
      send(128'h00000000_00000000_00000000_C1C1C1C1, 4'h1, 1'b1, 1'b0, 1'b1,
           128'h00000000_00000000_00000000_C1C1C1C1, 16'h000F, 4'b0011);

      // Back-to-back 4-beat CplDs with a 3-cycle downstream stall inside the second
      fork
         begin
            c0 = cyc;
            send_cpl4(8'h55, 32'h06005500, 32'hD0000000);
            chk("throughput_4_beats_cycles", 128'(cyc - c0), 128'd4);
            send_cpl4(8'h56, 32'h06005600, 32'hE0000000);
         end
         begin
            n = 0;
            while (acc_cnt < 14 && n < 200) begin
               @(posedge user_clk); #2;
               n++;
            end
            chk("stall_trigger_reached", 128'(acc_cnt >= 14), 128'd1);
            bus.m_axis_rc_tready_a = 1'b0;
            a0 = acc_cnt;
            repeat (3) @(posedge user_clk);
            #2;
            chk("stall_accepts_at_most_2", 128'((acc_cnt - a0) <= 2), 128'd1);
            chk("stall_tready_low", 128'(bus.m_axis_rc_tready), 128'd0);
            bus.m_axis_rc_tready_a = 1'b1;
         end
      join
      drain();

      // Reset in the middle of a 3-beat completion, then a fresh 1-DW CplD
      send({32'h12340000, desc(12'h010, 4'h0, 13'd32, 1'b0, 11'd8, 3'd0, 1'b0, 16'h0200, 8'h11,
                               16'h0008, 3'b101, 3'b110)}, 4'hF, 1'b0, 1'b1, 1'b0,
           {32'h12340000, 32'h02001110, 32'h00080020, 32'h4A502008}, 16'hFFFF, 4'b1000);
      send(128'h44444444_33333333_22222222_11111111, 4'hF, 1'b0, 1'b0, 1'b0,
           128'h44444444_33333333_22222222_11111111, 16'hFFFF, 4'b0000);
      drain();
      @(posedge user_clk); #1;
      user_reset_n = 1'b0;
      #1;
      chk_reset_outputs("mid_rst_assert");
      repeat (2) @(posedge user_clk);
      #1;
      chk_reset_outputs("mid_rst_hold");
      user_reset_n = 1'b1;
      chk("mid_rst_tready_before_edge", 128'(bus.m_axis_rc_tready), 128'd0);
      @(posedge user_clk); #1;
      chk("mid_rst_tready_after_edge", 128'(bus.m_axis_rc_tready), 128'h3FFFFF);

      send({32'hDEADBEEF, desc(12'h004, 4'h0, 13'd4, 1'b0, 11'd1, 3'd0, 1'b0, 16'h0100, 8'h05,
                               16'h0000, 3'd0, 3'd0)}, 4'hF, 1'b1, 1'b0, 1'b0,
           {32'hDEADBEEF, 32'h01000504, 32'h00000004, 32'h4A000001}, 16'hFFFF, 4'b1000);
      drain();

      repeat (3) @(posedge user_clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/m_axis_rc_adapt.md
# m_axis_rc_adapt

Requester-completion adapter for the 128-bit (x4) UltraScale+ PCIe hard-IP path. It takes completions from the core's RC interface in native descriptor format (3-DW RC descriptor followed by dword-aligned payload). It re-emits each completion as a legacy 3-DW-header completion TLP (CplD/Cpl/CplDLk/CplLk) on a registered AXI-Stream output toward the LitePCIe depacketizer. It also checks payload length against the descriptor dword count and flags mismatches.

## Interface
Parameters:
- DATA_WIDTH, 128, datapath width; only 128 is supported.
- KEEP_WIDTH, DATA_WIDTH/8, output byte-keep width.

Ports:
- user_clk  in  1  core user clock; sole clock.
- user_reset_n  in  1  asynchronous, active-low reset.
- m_axis_rc_tdata  in  128  RC descriptor and payload from the core.
- m_axis_rc_tkeep  in  4  dword keep from the core.
- m_axis_rc_tlast  in  1  end of completion.
- m_axis_rc_tuser  in  75  core sideband; [32] is_sof_0, [42] discontinue; other bits ignored.
- m_axis_rc_tvalid  in  1  core beat valid.
- m_axis_rc_tready  out  22  ready to the core; all bits identical.
- m_axis_rc_tdata_a  out  128  legacy TLP data.
- m_axis_rc_tkeep_a  out  KEEP_WIDTH  byte keep (each dword keep bit replicated x4).
- m_axis_rc_tlast_a  out  1  end of TLP.
- m_axis_rc_tuser_a  out  4  [0] discontinue, [1] error, [2] length mismatch, [3] sof.
- m_axis_rc_tvalid_a  out  1  output beat valid.
- m_axis_rc_tready_a  in  1  downstream ready.

## Operation
- FSM with two states:
  - HDR: the next accepted beat is a descriptor beat.
  - PKT: payload beats follow.
  - HDR -> PKT on an accepted beat with tlast=0.
  - PKT -> HDR on an accepted beat with tlast=1.
  - Any accepted beat in HDR is treated as a descriptor, whatever is_sof_0 says.
- Descriptor fields:
  - addr = d[11:0], err = d[15:12], bc = d[28:16], lock = d[29]
  - dwc = d[42:32], st = d[45:43], ep = d[46], rid = d[63:48]
  - tag = d[71:64], cid = d[87:72], tc = d[91:89], attr = d[94:92]
- Legacy header, beat 0:
  - DW0 = {fmt, type, 1'b0, tc, 4'b0, td=0, EP, attr[1:0], 2'b0, len}, where:
    - fmt = 3'b010 if dwc != 0, else 3'b000.
    - type = 5'b01011 if lock, else 5'b01010.
    - EP = ep | (err != 0).
    - len = dwc[9:0] (1024 encodes as 0).
  - DW1 = {cid, st, bcm=0, bc[11:0]}; a bc of 4096 encodes as 0.
  - DW2 = {rid, tag, 1'b0, addr[6:0]}.
  - DW3 = input tdata[127:96], passed through unchanged (first payload dword).
- Payload beats pass through unshifted; descriptor and legacy header are both 3 DW.
- tuser_a on every beat:
  - [0] = input discontinue.
  - [3] = 1 on beat 0 only.
  - [1] = EP, latched at beat 0 and held for all beats of the TLP.
- Length check:
  - At beat 0, load an 11-bit counter rem = dwc − keep[3].
  - Each later beat, subtract popcount(keep).
  - [2] is asserted on the tlast beat when the remaining count after that beat is ≠ 0.
  - Underflow wraps; any nonzero result sets [2].
- Output stage is a 2-entry skid buffer.
  - m_axis_rc_tready = buffer not full; it is driven from a register.
  - Data is never dropped or duplicated.

## Timing
- Reset (user_reset_n low, async assert, sync release):
  - FSM = HDR, rem = 0, buffer empty.
  - m_axis_rc_tvalid_a = 0, m_axis_rc_tlast_a = 0, m_axis_rc_tuser_a = 0, m_axis_rc_tready = 0.
  - m_axis_rc_tready rises on the first user_clk edge after release.
- Latency is 1 cycle: an input beat accepted at edge N is presented at m_axis_rc_tvalid_a after edge N.
- With tready_a held high, throughput is 1 beat/cycle with no bubbles.
- When tready_a drops, at most 2 further input beats are accepted. m_axis_rc_tready falls in the cycle the second entry fills.
- Output tdata_a, tkeep_a, tlast_a and tuser_a hold stable while tvalid_a=1 and tready_a=0.
- A reset asserted mid-packet discards buffered beats. The first beat after release is parsed as a descriptor.

## Test plan
- 1-DW CplD: addr=0x004, bc=4, dwc=1, st=0, rid=0x0100, tag=0x05, cid=0, payload 0xDEADBEEF, keep=4'hF, tlast -> one beat:
  - DW0=0x4A000001, DW1=0x00000004, DW2=0x01000504, DW3=0xDEADBEEF.
  - tkeep_a=16'hFFFF, tlast_a=1, tuser_a=4'b1000.
- 8-DW CplD in 3 beats (keep F, F, 7) -> 3 output beats:
  - Last beat has tkeep_a=16'h0FFF.
  - tuser_a[2]=0; tuser_a[3] is set only on beat 0.
- UR completion: dwc=0, st=3'b001, bc=4096, keep=4'h7, tlast -> DW0=0x0A000000, DW1[15:0]=0x2000, tkeep_a=16'h0FFF.
- Truncated: dwc=8 with tlast on beat 2 (keep F, F) -> tuser_a[2]=1 on the last beat only.
  - Second case: err=4'h1 -> DW0 bit14=1 and tuser_a[1]=1 on all beats.
- Back-to-back 4-beat CplDs with tready_a low for 3 cycles mid-packet -> output sequence identical to the input sequence, m_axis_rc_tready low within 2 accepted beats, and the FSM resumes correctly.
- Assert user_reset_n low after beat 1 of a 3-beat completion, then send a fresh 1-DW CplD -> all outputs 0 during reset, and the new completion is converted as in the first scenario.
